// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Two-master / one-slave Wishbone B4 classic arbiter. Master 0 is the
//   instruction-fetch bus unit, master 1 the load/store bus unit. Grant is
//   round-robin between simultaneous requesters. The owner keeps the bus for
//   as long as its CYC stays high. A watchdog returns ERR to the owner when
//   the slave stalls for TIMEOUT_CYCLES cycles.
//
// Ports
//   CLK_I, RST_I              clock, asynchronous active-low reset
//   Mx_CYC_I/STB_I/WE_I       master x bus controls
//   Mx_SEL_I/ADR_I/DAT_I      master x byte select, address, write data
//   Mx_ACK_O/ERR_O/DAT_O      master x acknowledge, error, read data
//   S_CYC_O/STB_O/WE_O        slave-side controls (muxed from the owner)
//   S_SEL_O/ADR_O/DAT_O       slave-side byte select, address, write data
//   S_ACK_I, S_DAT_I          slave acknowledge and read data
//   GNT_O                     one-hot grant from the state register (01=M0, 10=M1)
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [3:0]  M0_SEL_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  output logic        M0_ACK_O,
  output logic        M0_ERR_O,
  output logic [31:0] M0_DAT_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [3:0]  M1_SEL_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  output logic        M1_ACK_O,
  output logic        M1_ERR_O,
  output logic [31:0] M1_DAT_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [3:0]  S_SEL_O,
  output logic [31:0] S_ADR_O,
  output logic [31:0] S_DAT_O,
  input  logic        S_ACK_I,
  input  logic [31:0] S_DAT_I,
  output logic [1:0]  GNT_O
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             last_owner_reg, last_owner_next;
  logic [CNT_W-1:0] wdog_reg, wdog_next;

  // Master-side signals gathered into arrays so both masters share one mux.
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [1:0]  m_ack, m_err;

  assign m_cyc    = {M1_CYC_I, M0_CYC_I};
  assign m_stb    = {M1_STB_I, M0_STB_I};
  assign m_we     = {M1_WE_I,  M0_WE_I};
  assign m_sel[0] = M0_SEL_I;
  assign m_sel[1] = M1_SEL_I;
  assign m_adr[0] = M0_ADR_I;
  assign m_adr[1] = M1_ADR_I;
  assign m_dat[0] = M0_DAT_I;
  assign m_dat[1] = M1_DAT_I;

  logic owned;      // some master holds the bus
  logic owner;      // which master, meaningful only when owned
  logic timeout;    // watchdog fires this cycle
  logic grant_sel;  // master picked by IDLE arbitration

  assign owned = (state_reg == OWN0) || (state_reg == OWN1);
  assign owner = (state_reg == OWN1);

  // A slave ACK in the expiry cycle completes the transfer normally, so it
  // suppresses the timeout.
  assign timeout = owned && (wdog_reg == CNT_W'(TIMEOUT_CYCLES)) && !S_ACK_I;

  // A lone requester wins outright; on a tie the master that did not own
  // the bus last time wins.
  assign grant_sel = (&m_cyc) ? ~last_owner_reg : m_cyc[1];

  assign GNT_O = {state_reg == OWN1, state_reg == OWN0};

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      wdog_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      wdog_reg       <= wdog_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    wdog_next       = wdog_reg;
    case (state_reg)
      IDLE: begin
        wdog_next = '0;
        if (|m_cyc) begin
          state_next      = grant_sel ? OWN1 : OWN0;
          last_owner_next = grant_sel;
        end
      end
      OWN0, OWN1: begin
        if (timeout) begin
          // Abandon the hung transfer even if the owner still holds CYC.
          state_next = IDLE;
          wdog_next  = '0;
        end else if (!m_cyc[owner]) begin
          // Release: hand straight over if the other master is waiting.
          wdog_next = '0;
          if (m_cyc[~owner]) begin
            state_next      = owner ? OWN0 : OWN1;
            last_owner_next = ~owner;
          end else begin
            state_next = IDLE;
          end
        end else if (S_ACK_I) begin
          wdog_next = '0;
        end else if (m_stb[owner]) begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        wdog_next  = '0;
      end
    endcase
  end

  // Slave-side mux; bus is driven to zero whenever no master owns it, and
  // CYC/STB are pulled down in the timeout cycle to terminate the cycle.
  always_comb begin
    S_CYC_O = 1'b0;
    S_STB_O = 1'b0;
    S_WE_O  = 1'b0;
    S_SEL_O = '0;
    S_ADR_O = '0;
    S_DAT_O = '0;
    if (owned) begin
      S_CYC_O = m_cyc[owner] && !timeout;
      S_STB_O = m_stb[owner] && !timeout;
      S_WE_O  = m_we[owner];
      S_SEL_O = m_sel[owner];
      S_ADR_O = m_adr[owner];
      S_DAT_O = m_dat[owner];
    end
  end

  // Responses go only to the current owner; ACK and ERR are exclusive
  // because timeout already excludes S_ACK_I.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign m_ack[gi] = owned && (owner == 1'(gi)) && S_ACK_I;
      assign m_err[gi] = (owner == 1'(gi)) && timeout;
    end
  endgenerate

  assign M0_ACK_O = m_ack[0];
  assign M1_ACK_O = m_ack[1];
  assign M0_ERR_O = m_err[0];
  assign M1_ERR_O = m_err[1];
  assign M0_DAT_O = S_DAT_I;
  assign M1_DAT_O = S_DAT_I;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Testbench for wb_bus_arbiter: directed scenarios with hand-computed
// expectations, followed by randomized traffic, all checked every cycle
// against a transaction-level model of ownership and slave stall time.
module tb_wb_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat[2];
  logic        m_ack [2];
  logic        m_err [2];
  logic [31:0] m_rdat[2];
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o;
  logic        s_ack;
  logic [31:0] s_dat_i;
  logic [1:0]  gnt;

  int n_vec  = 0;
  int n_fail = 0;
  bit run_checks = 1'b0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .CLK_I(clk), .RST_I(rst_n),
    .M0_CYC_I(m_cyc[0]), .M0_STB_I(m_stb[0]), .M0_WE_I(m_we[0]),
    .M0_SEL_I(m_sel[0]), .M0_ADR_I(m_adr[0]), .M0_DAT_I(m_wdat[0]),
    .M0_ACK_O(m_ack[0]), .M0_ERR_O(m_err[0]), .M0_DAT_O(m_rdat[0]),
    .M1_CYC_I(m_cyc[1]), .M1_STB_I(m_stb[1]), .M1_WE_I(m_we[1]),
    .M1_SEL_I(m_sel[1]), .M1_ADR_I(m_adr[1]), .M1_DAT_I(m_wdat[1]),
    .M1_ACK_O(m_ack[1]), .M1_ERR_O(m_err[1]), .M1_DAT_O(m_rdat[1]),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_SEL_O(s_sel),
    .S_ADR_O(s_adr), .S_DAT_O(s_dat_o), .S_ACK_I(s_ack), .S_DAT_I(s_dat_i),
    .GNT_O(gnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), who was granted last, and how many
  // cycles the owner's strobe has gone unanswered.
  int mdl_owner = -1;
  int mdl_last  = 1;
  int mdl_stall = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_owner <= -1;
      mdl_last  <= 1;
      mdl_stall <= 0;
    end else if (mdl_owner < 0) begin
      int pick;
      if (m_cyc[0] && m_cyc[1]) pick = 1 - mdl_last;
      else if (m_cyc[0])        pick = 0;
      else if (m_cyc[1])        pick = 1;
      else                      pick = -1;
      mdl_owner <= pick;
      if (pick >= 0) mdl_last <= pick;
      mdl_stall <= 0;
    end else if (mdl_stall == TO && !s_ack) begin
      mdl_owner <= -1;
      mdl_stall <= 0;
    end else if (!m_cyc[mdl_owner]) begin
      if (m_cyc[1 - mdl_owner]) begin
        mdl_owner <= 1 - mdl_owner;
        mdl_last  <= 1 - mdl_owner;
      end else begin
        mdl_owner <= -1;
      end
      mdl_stall <= 0;
    end else if (s_ack) begin
      mdl_stall <= 0;
    end else if (m_stb[mdl_owner]) begin
      mdl_stall <= mdl_stall + 1;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (run_checks) begin : cmp
      int o;
      logic to;
      logic [1:0] e_gnt;
      o = mdl_owner;
      to = (o >= 0) && (mdl_stall == TO) && !s_ack;
      e_gnt = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
      chk("gnt", gnt, e_gnt);
      chk("s_cyc", s_cyc, (o >= 0) ? (m_cyc[o] && !to) : 1'b0);
      chk("s_stb", s_stb, (o >= 0) ? (m_stb[o] && !to) : 1'b0);
      chk("s_we",  s_we,  (o >= 0) ? m_we[o]   : 1'b0);
      chk("s_sel", s_sel, (o >= 0) ? m_sel[o]  : 4'h0);
      chk("s_adr", s_adr, (o >= 0) ? m_adr[o]  : 32'h0);
      chk("s_dat", s_dat_o, (o >= 0) ? m_wdat[o] : 32'h0);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_ack", m), m_ack[m], (o == m) && s_ack);
        chk($sformatf("m%0d_err", m), m_err[m], (o == m) && to);
        chk($sformatf("m%0d_dat", m), m_rdat[m], s_dat_i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int ack_pct;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 0; m_stb[m] = 0; m_we[m] = 0;
      m_sel[m] = 4'h0; m_adr[m] = 32'h0; m_wdat[m] = 32'h0;
    end
    s_ack = 0;
    s_dat_i = 32'h0;
    repeat (2) step();
    rst_n = 1'b1;
    run_checks = 1'b1;
    @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);

    // Single M0 read with two wait states.
    step();
    set_m(0, 1, 1); m_sel[0] = 4'hF; m_adr[0] = 32'h100;
    @(negedge clk); chk("t1_gnt_pre", gnt, 2'b00);
    step();
    @(negedge clk); chk("t1_gnt", gnt, 2'b01); chk("t1_s_stb", s_stb, 1'b1);
    chk("t1_ack_ws1", m_ack[0], 1'b0);
    step();
    @(negedge clk); chk("t1_ack_ws2", m_ack[0], 1'b0);
    step();
    s_ack = 1; s_dat_i = 32'hCAFEBABE;
    @(negedge clk); chk("t1_ack", m_ack[0], 1'b1); chk("t1_dat", m_rdat[0], 32'hCAFEBABE);
    chk("t1_m1_ack", m_ack[1], 1'b0);
    step();
    s_ack = 0; set_m(0, 0, 0);
    @(negedge clk); chk("t1_ack_after", m_ack[0], 1'b0);
    step();
    @(negedge clk); chk("t1_idle", gnt, 2'b00);

    // Simultaneous requests from reset, then handoff, then round robin.
    pulse_reset();
    set_m(0, 1, 1); set_m(1, 1, 1);
    step();
    @(negedge clk); chk("t2_first", gnt, 2'b01);
    step();
    s_ack = 1;
    @(negedge clk); chk("t2_m0_ack", m_ack[0], 1'b1); chk("t2_m1_noack", m_ack[1], 1'b0);
    step();
    s_ack = 0; set_m(0, 0, 0);
    @(negedge clk); chk("t2_hold", gnt, 2'b01);
    step();
    @(negedge clk); chk("t2_handoff", gnt, 2'b10);
    s_ack = 1;
    @(negedge clk);
    step();
    s_ack = 0; set_m(1, 0, 0);
    step();
    @(negedge clk); chk("t2_idle", gnt, 2'b00);
    set_m(0, 1, 1); set_m(1, 1, 1);
    step();
    @(negedge clk); chk("t2_rr", gnt, 2'b01);
    set_m(0, 0, 0); set_m(1, 0, 0);
    step(); step();

    // M1 locks the bus for three back-to-back writes while M0 waits.
    set_m(1, 1, 1); m_we[1] = 1; m_sel[1] = 4'h3; m_adr[1] = 32'h200; m_wdat[1] = 32'h55AA;
    step();
    set_m(0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      s_ack = 1;
      @(negedge clk);
      chk("t3_gnt", gnt, 2'b10); chk("t3_ack", m_ack[1], 1'b1);
      chk("t3_we", s_we, 1'b1); chk("t3_sel", s_sel, 4'h3);
      step();
      s_ack = 0;
      @(negedge clk); chk("t3_gnt_gap", gnt, 2'b10);
      step();
    end
    set_m(1, 0, 0); m_we[1] = 0;
    @(negedge clk); chk("t3_still_m1", gnt, 2'b10);
    step();
    @(negedge clk); chk("t3_m0_after", gnt, 2'b01);
    set_m(0, 0, 0);
    step(); step();

    // Slave never answers: ERR after TO cycles of stall.
    set_m(0, 1, 1);
    step();
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); chk("t4_no_err", m_err[0], 1'b0); chk("t4_s_cyc", s_cyc, 1'b1);
      step();
    end
    @(negedge clk);
    chk("t4_err", m_err[0], 1'b1); chk("t4_s_cyc_cut", s_cyc, 1'b0);
    chk("t4_s_stb_cut", s_stb, 1'b0);
    step();
    @(negedge clk); chk("t4_idle", gnt, 2'b00);
    set_m(0, 0, 0);
    step(); step();

    // ACK lands in the cycle the watchdog would fire.
    set_m(0, 1, 1);
    step();
    repeat (TO) step();
    s_ack = 1;
    @(negedge clk);
    chk("t5_ack", m_ack[0], 1'b1); chk("t5_no_err", m_err[0], 1'b0);
    chk("t5_s_cyc", s_cyc, 1'b1);
    step();
    s_ack = 0;
    @(negedge clk); chk("t5_kept", gnt, 2'b01);
    set_m(0, 0, 0);
    step(); step();

    // Asynchronous reset while M1 owns the bus.
    set_m(1, 1, 1); m_adr[1] = 32'h300;
    step();
    @(negedge clk); chk("t6_gnt", gnt, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_s_cyc", s_cyc, 1'b0); chk("t6_s_stb", s_stb, 1'b0);
    chk("t6_s_adr", s_adr, 32'h0); chk("t6_gnt0", gnt, 2'b00);
    step();
    rst_n = 1'b1;
    set_m(0, 1, 1);
    step();
    @(negedge clk); chk("t6_m0_first", gnt, 2'b01);
    set_m(0, 0, 0); set_m(1, 0, 0);
    step(); step();

    // Randomized traffic.
    ack_pct = 30;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i % 500 == 0) ack_pct = (i % 1500 == 0) ? 10 : ((i % 1000 == 0) ? 60 : 30);
      rst_n = ($urandom_range(0, 599) != 0);
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m]) begin
          if ($urandom_range(0, 7) == 0) set_m(m, 0, 0);
          else m_stb[m] = ($urandom_range(0, 3) != 0);
        end else if ($urandom_range(0, 3) == 0) begin
          set_m(m, 1, 1);
        end
        m_we[m]   = 1'($urandom_range(0, 1));
        m_sel[m]  = 4'($urandom_range(0, 15));
        m_adr[m]  = $urandom;
        m_wdat[m] = $urandom;
      end
      s_ack   = ($urandom_range(0, 99) < ack_pct);
      s_dat_i = $urandom;
    end
    step();
    rst_n = 1'b1;
    set_m(0, 0, 0); set_m(1, 0, 0); s_ack = 0;
    step(); step();
    run_checks = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter.
- Shares the single external bus between the instruction-fetch bus unit (M0) and the load/store bus unit (M1). Both masters are instances of the CPU bus interface.
- Fair round-robin grant with per-transaction lock.
- Hung-slave watchdog: ERR is returned to the owning master on timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles of granted STB without slave ACK before ERR is raised. Legal range 1..2^CNT_W-1.
- CNT_W, 8: watchdog counter width.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset, asynchronous, active-low
- M0_CYC_I, M0_STB_I, M0_WE_I  in  1 each  master 0 Wishbone controls
- M0_SEL_I  in  4  master 0 byte select
- M0_ADR_I, M0_DAT_I  in  32 each  master 0 address and write data
- M0_ACK_O, M0_ERR_O  out  1 each  master 0 acknowledge and error
- M0_DAT_O  out  32  read data to master 0
- M1_*  same set as M0_*  master 1
- S_CYC_O, S_STB_O, S_WE_O  out  1 each  slave-side controls
- S_SEL_O  out  4  slave-side byte select
- S_ADR_O, S_DAT_O  out  32 each  slave-side address and write data
- S_ACK_I  in  1  slave acknowledge
- S_DAT_I  in  32  slave read data
- GNT_O  out  2  registered one-hot grant: 01=M0, 10=M1, 00=idle

Behaviour:
- State machine: IDLE, OWN0, OWN1.
  - Registers: state, last_owner (1 bit, reset 1), wdog (CNT_W bits).
- Reset (RST_I low, asynchronous):
  - state=IDLE, wdog=0, last_owner=1.
  - All slave outputs 0; all ACK/ERR outputs 0; GNT_O=00.
  - A transaction in flight is abandoned; no ACK is forwarded.
- Arbitration, evaluated in IDLE each edge:
  - Request = Mx_CYC_I.
  - Only one master requesting: grant it.
  - Both requesting: grant the master that is not last_owner.
  - last_owner updates on every grant.
  - Grant latency: request sampled at edge N; the slave sees the muxed STB from cycle N+1.
- Lock: the owner keeps the bus while its CYC_I is high, including back-to-back STB cycles.
  - The other master's requests are ignored for the duration.
- Release: sampled at an edge with the owner's CYC_I low.
  - If the other master's CYC_I is high, go directly to its OWN state (handoff, no idle cycle).
  - Otherwise go to IDLE.
- Slave-side mux (combinational from state):
  - In OWNx, S_* equal Mx_* inputs.
  - In IDLE, all S_* outputs are 0.
- Response routing:
  - S_DAT_I is broadcast to both Mx_DAT_O.
  - S_ACK_I is forwarded only to the owner's ACK.
  - Non-owner ACK and ERR are held 0.
  - An ACK arriving in IDLE is dropped.
- Watchdog:
  - wdog increments each cycle the owner's STB is high and S_ACK_I is low.
  - It clears on S_ACK_I, on release, and in IDLE.
  - When wdog==TIMEOUT_CYCLES:
    - Owner ERR_O is asserted combinationally for that one cycle.
    - S_CYC_O and S_STB_O are forced 0 that cycle.
    - wdog clears.
    - At the next edge state goes to IDLE, even if the owner's CYC_I is still high; normal arbitration resumes from IDLE.
- Simultaneous events:
  - ACK in the same cycle as timeout: ACK wins, no ERR.
  - The owner may drop CYC in the ACK cycle; handoff occurs at that edge.
- ACK and ERR are never both high to one master.

Test Plan:
- Single M0 read, slave ACKs after 2 wait states, S_DAT_I=32'hCAFEBABE:
  - GNT_O=01 one cycle after M0_CYC_I.
  - M0_ACK_O pulses once; M0_DAT_O=32'hCAFEBABE; M1_ACK_O stays 0.
- M0 and M1 raise CYC in the same cycle from reset:
  - M0 granted first (last_owner=1).
  - On M0 release, M1 granted at that edge with no IDLE cycle.
  - The next simultaneous request grants M0.
- M1 holds CYC across 3 back-to-back writes while M0 requests:
  - GNT_O stays 10 for all 3 ACKs.
  - M0 is granted only after M1 drops CYC.
  - S_WE_O and S_SEL_O track M1 values.
- Slave never ACKs, TIMEOUT_CYCLES=4:
  - M0_ERR_O pulses exactly 4 cycles after STB is first seen on the slave.
  - S_CYC_O is 0 in that cycle; GNT_O=00 the next cycle.
- ACK and timeout in the same cycle:
  - Owner receives ACK only; ERR_O=0.
- RST_I driven low mid-transaction (M1 owner, STB high):
  - All S_* outputs and GNT_O go 0 immediately, without waiting for a clock edge.
  - After release, a simultaneous request grants M0 first.
